// File: rtl/mem_responder.sv
// mem_responder: far end of the CPU's 2-bit serial TX/RX link.
// Deserializes request frames from tx_pins and services RD16/WR16/RD8/WR8
// against an internal byte RAM. Read replies are serialized back on rx_pins.
//
// Ports
//   clk        in   1          clock
//   reset      in   1          synchronous, active-high
//   tx_pins    in   NSHIFT     CPU->memory symbols
//   rx_pins    out  NSHIFT     memory->CPU symbols, 2'b00 when idle
//   busy       out  1          high in every state except IDLE
//   load_en    in   1          preload strobe (works in any state)
//   load_addr  in   ADDR_BITS  preload byte address
//   load_data  in   8          preload byte
//
// Build option: MEM_RESPONDER_WRITE_ACK_EN adds an ACK state that drives
// rx_pins=2'b11 for one cycle after every write frame.
//
// state  | meaning
// IDLE   | waiting for start symbol (tx_pins[0]=1)
// CMD    | latch command symbol
// ADDR   | shift in 8 address symbols, LSB first
// DATA   | shift in 8 write-data symbols, LSB first
// WAIT   | REPLY_DELAY cycles, RAM read registered
// RSTART | drive reply start symbol 2'b01
// RDATA  | shift out 8 reply symbols, LSB first
// ACK    | write acknowledge 2'b11 (option only)
module mem_responder #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int ADDR_BITS      = 8,
  parameter int REPLY_DELAY    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSHIFT-1:0]    tx_pins,
  output logic [NSHIFT-1:0]    rx_pins,
  output logic                 busy,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data
);

  localparam int FW = NSHIFT * PAYLOAD_CYCLES;
  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_WAIT, S_RSTART, S_RDATA, S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [FW-1:0]       addr_q, addr_d;
  logic [FW-1:0]       data_q, data_d;
  logic [FW-1:0]       rd_q, rd_d;
  logic [NSHIFT-1:0]   rx_q, rx_d;
  logic                busy_q;
  logic                wr_pend_q, wr_pend_d;

  logic [7:0]          mem [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0] a_lo, a_hi;
  logic                unused_addr;

  // Upper address bits alias onto the RAM; the +1 byte wraps naturally.
  assign a_lo        = addr_q[ADDR_BITS-1:0];
  assign a_hi        = a_lo + 1'b1;
  assign unused_addr = ^addr_q[FW-1:ADDR_BITS];

  assign rx_pins = rx_q;
  assign busy    = busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    rx_d      = '0;
    wr_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_pins[0]) state_d = S_CMD;
      end
      S_CMD: begin
        cmd_d   = tx_pins;
        cnt_d   = CW'(PAYLOAD_CYCLES - 1);
        state_d = S_ADDR;
      end
      S_ADDR: begin
        addr_d = {tx_pins, addr_q[FW-1:NSHIFT]};
        if (cnt_q == '0) begin
          if (cmd_q[0]) begin
            cnt_d   = CW'(PAYLOAD_CYCLES - 1);
            state_d = S_DATA;
          end else begin
            cnt_d   = CW'(REPLY_DELAY - 1);
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        data_d = {tx_pins, data_q[FW-1:NSHIFT]};
        if (cnt_q == '0) begin
          // Commit happens on the following edge from the captured fields.
          wr_pend_d = 1'b1;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
          state_d = S_ACK;
          rx_d    = {NSHIFT{1'b1}};
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        rd_d = cmd_q[1] ? {8'h00, mem[a_lo]} : {mem[a_hi], mem[a_lo]};
        if (cnt_q == '0) begin
          state_d = S_RSTART;
          rx_d    = NSHIFT'(1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RSTART: begin
        rx_d    = rd_q[NSHIFT-1:0];
        rd_d    = rd_q >> NSHIFT;
        cnt_d   = CW'(PAYLOAD_CYCLES - 1);
        state_d = S_RDATA;
      end
      S_RDATA: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rx_d  = rd_q[NSHIFT-1:0];
          rd_d  = rd_q >> NSHIFT;
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef MEM_RESPONDER_WRITE_ACK_EN
      S_ACK: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // rx/busy are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      rx_q      <= '0;
      busy_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      rx_q      <= rx_d;
      busy_q    <= (state_d != S_IDLE);
      wr_pend_q <= wr_pend_d;
    end
  end

  // RAM is never cleared. The preload assignment comes last so it wins
  // over a frame write to the same byte on the same edge.
  always_ff @(posedge clk) begin
    if (wr_pend_q && !reset) begin
      mem[a_lo] <= data_q[7:0];
      if (!cmd_q[1]) mem[a_hi] <= data_q[15:8];
    end
    if (load_en) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed frames, scoreboard queue of expected
// replies, and an independent monitor that decodes rx_pins.
module tb_mem_responder;

  localparam int RD = 1;

`ifdef MEM_RESPONDER_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] tx_pins = 2'b00;
  logic [1:0] rx_pins;
  logic       busy;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          start;
  } exp_t;
  exp_t sb[$];

  mem_responder #(.NSHIFT(2), .PAYLOAD_CYCLES(8), .ADDR_BITS(8), .REPLY_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .tx_pins(tx_pins), .rx_pins(rx_pins), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic sym(input logic [1:0] s);
    tx_pins = s;
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic send_hdr(input logic [1:0] cmd, input logic [15:0] a);
    sym(2'b01);
    sym(cmd);
    for (int i = 0; i < 8; i++) sym(a[2*i +: 2]);
  endtask

  // Returns at the negedge after the edge that sampled the last address symbol.
  task automatic rd(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] expv);
    exp_t e;
    send_hdr(cmd, a);
    tx_pins = 2'b00;
    e.data  = expv;
    e.start = cyc + RD;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] d,
                    input bit do_load, input logic [7:0] la, input logic [7:0] ld);
    send_hdr(cmd, a);
    for (int i = 0; i < 8; i++) sym(d[2*i +: 2]);
    tx_pins = 2'b00;
    if (do_load) begin
      load_en = 1'b1; load_addr = la; load_data = ld;
    end
    if (ACK) begin
      chk("write_ack_sym", {14'h0, rx_pins}, 16'h0003);
      chk("write_ack_busy", {15'h0, busy}, 16'h0001);
    end else begin
      chk("write_no_rx", {14'h0, rx_pins}, 16'h0000);
      chk("write_idle_busy", {15'h0, busy}, 16'h0000);
    end
    if (do_load || ACK) begin
      @(negedge clk);
      load_en = 1'b0;
      chk("after_write_rx", {14'h0, rx_pins}, 16'h0000);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got busy=%0d pending=%0d required idle within 200 cycles", busy, sb.size());
    end
  endtask

  // Monitor: decode every reply frame and compare against the scoreboard.
  initial begin
    logic [15:0] word;
    int          sc;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset && rx_pins == 2'b01) begin
        sc   = cyc;
        word = 16'h0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          word[2*i +: 2] = rx_pins;
        end
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_reply: got %h required no reply", word);
        end else begin
          e = sb.pop_front();
          chk("reply_data", word, e.data);
          chk("reply_start_cycle", 16'(sc), 16'(e.start));
        end
        @(negedge clk);
        chk("reply_end_rx", {14'h0, rx_pins}, 16'h0000);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rx", {14'h0, rx_pins}, 16'h0000);
    chk("reset_busy", {15'h0, busy}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    preload(8'h10, 8'h34);
    preload(8'h11, 8'h12);
    preload(8'h21, 8'h77);
    preload(8'h34, 8'h5A);
    preload(8'h35, 8'hC3);

    rd(2'd0, 16'h0010, 16'h1234);
    wait_idle();

    // Wrap on a+1, back-to-back read after the write.
    wr(2'd1, 16'h00FF, 16'hBEEF, 1'b0, 8'h00, 8'h00);
    rd(2'd0, 16'h00FF, 16'hBEEF);
    wait_idle();
    rd(2'd2, 16'h0000, 16'h00BE);
    wait_idle();
    rd(2'd2, 16'h00FF, 16'h00EF);
    wait_idle();

    wr(2'd3, 16'h0020, 16'hAA55, 1'b0, 8'h00, 8'h00);
    rd(2'd2, 16'h0020, 16'h0055);
    wait_idle();
    rd(2'd0, 16'h0020, 16'h7755);
    wait_idle();

    // Aliased address; start symbols during WAIT/RSTART/RDATA are dropped.
    rd(2'd0, 16'h1234, 16'hC35A);
    for (int i = 0; i < 9; i++) begin
      tx_pins = 2'b01;
      chk("busy_during_reply", {15'h0, busy}, 16'h0001);
      @(negedge clk);
    end
    tx_pins = 2'b00;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("dropped_start_idle", {15'h0, busy}, 16'h0000);

    // Reset in the middle of a WR16 address phase.
    sym(2'b01);
    sym(2'd1);
    sym(2'b00); sym(2'b00); sym(2'b01);
    chk("busy_mid_addr", {15'h0, busy}, 16'h0001);
    reset = 1'b1;
    tx_pins = 2'b00;
    @(negedge clk);
    chk("abort_busy", {15'h0, busy}, 16'h0000);
    chk("abort_rx", {14'h0, rx_pins}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    rd(2'd0, 16'h0010, 16'h1234);
    wait_idle();

    // Preload colliding with the commit edge on the upper byte wins.
    wr(2'd1, 16'h0040, 16'h2211, 1'b1, 8'h41, 8'h99);
    rd(2'd0, 16'h0040, 16'h9911);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
